// File: rtl/vga_txt_scroll_ctl_pkg.sv
// vga_txt_pkg: text-buffer geometry, command opcodes and sequencer states for vga_txt_scroll_ctl.
package vga_txt_pkg;
   localparam logic [9:0] ROW_WORDS       = 10'd20;
   localparam logic [9:0] ROWS            = 10'd30;
   localparam logic [9:0] TOTAL_WORDS     = ROW_WORDS * ROWS;
   localparam logic [9:0] LAST_WORD       = TOTAL_WORDS - 10'd1;
   localparam logic [9:0] SCROLL_SRC_LAST = TOTAL_WORDS - ROW_WORDS - 10'd1;
   localparam logic [1:0] OP_CLEAR        = 2'b00;
   localparam logic [1:0] OP_SCROLL_UP    = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_RESP, S_DONE} state_e;
endpackage

// File: rtl/vga_txt_scroll_ctl_axil_single_beat.sv
// axil_single_beat: one AXI4-Lite write (AW/W/B) or read (AR/R) per start pulse; ack on the final handshake.
module axil_single_beat
   import vga_txt_pkg::*;
#(
   parameter int AW = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          rw,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic          ack,
   output logic [31:0]   rdata,
   output logic          resp_err,
   output logic          M_AXI_AWVALID,
   input  logic          M_AXI_AWREADY,
   output logic [AW-1:0] M_AXI_AWADDR,
   output logic [2:0]    M_AXI_AWPROT,
   output logic          M_AXI_WVALID,
   input  logic          M_AXI_WREADY,
   output logic [31:0]   M_AXI_WDATA,
   output logic [3:0]    M_AXI_WSTRB,
   input  logic          M_AXI_BVALID,
   output logic          M_AXI_BREADY,
   input  logic [1:0]    M_AXI_BRESP,
   output logic          M_AXI_ARVALID,
   input  logic          M_AXI_ARREADY,
   output logic [AW-1:0] M_AXI_ARADDR,
   output logic [2:0]    M_AXI_ARPROT,
   input  logic          M_AXI_RVALID,
   output logic          M_AXI_RREADY,
   input  logic [31:0]   M_AXI_RDATA,
   input  logic [1:0]    M_AXI_RRESP
);
   logic aw_q, w_q, b_q, ar_q, r_q;
   logic [AW-1:0] addr_q;
   logic [31:0] wdata_q;
   logic b_hs, r_hs;
   assign b_hs = b_q && M_AXI_BVALID;
   assign r_hs = r_q && M_AXI_RVALID;
   assign ack = b_hs || r_hs;
   assign resp_err = (b_hs && M_AXI_BRESP != AXI_RESP_OKAY) || (r_hs && M_AXI_RRESP != AXI_RESP_OKAY);
   assign rdata = M_AXI_RDATA;
   assign M_AXI_AWVALID = aw_q;
   assign M_AXI_AWADDR = addr_q;
   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_WVALID = w_q;
   assign M_AXI_WDATA = wdata_q;
   assign M_AXI_WSTRB = 4'b1111;
   assign M_AXI_BREADY = b_q;
   assign M_AXI_ARVALID = ar_q;
   assign M_AXI_ARADDR = addr_q;
   assign M_AXI_ARPROT = 3'b000;
   assign M_AXI_RREADY = r_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         aw_q <= 1'b0;
         w_q <= 1'b0;
         b_q <= 1'b0;
         ar_q <= 1'b0;
         r_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
      end else begin
         if (start) begin
            addr_q <= addr;
            wdata_q <= wdata;
         end
         aw_q <= start ? rw : aw_q && !M_AXI_AWREADY;
         w_q <= start ? rw : w_q && !M_AXI_WREADY;
         // B phase opens only once both AW and W have been accepted, in whatever order
         b_q <= ((aw_q || w_q) && (!aw_q || M_AXI_AWREADY) && (!w_q || M_AXI_WREADY)) || (b_q && !M_AXI_BVALID);
         ar_q <= start ? !rw : ar_q && !M_AXI_ARREADY;
         r_q <= (ar_q && M_AXI_ARREADY) || (r_q && !M_AXI_RVALID);
      end
endmodule

// File: rtl/vga_txt_scroll_ctl.sv
// vga_txt_scroll_ctl: CLEAR / SCROLL_UP sequencer over the 80x30 text buffer via one AXI4-Lite beat at a time.
// Define VGA_TXT_ERR_ABORT_EN to end a command on its first non-OKAY response.
module vga_txt_scroll_ctl
   import vga_txt_pkg::*;
#(
   parameter int C_AXI_ADDR_WIDTH = 12,
   parameter int C_AXI_DATA_WIDTH = 32
) (
   input  logic                        S_AXI_ACLK,
   input  logic                        S_AXI_ARESETN,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [1:0]                  cmd_op,
   input  logic [7:0]                  cmd_fill,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   output logic                        M_AXI_AWVALID,
   input  logic                        M_AXI_AWREADY,
   output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic [2:0]                  M_AXI_AWPROT,
   output logic                        M_AXI_WVALID,
   input  logic                        M_AXI_WREADY,
   output logic [C_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
   output logic [3:0]                  M_AXI_WSTRB,
   input  logic                        M_AXI_BVALID,
   output logic                        M_AXI_BREADY,
   input  logic [1:0]                  M_AXI_BRESP,
   output logic                        M_AXI_ARVALID,
   input  logic                        M_AXI_ARREADY,
   output logic [C_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [2:0]                  M_AXI_ARPROT,
   input  logic                        M_AXI_RVALID,
   output logic                        M_AXI_RREADY,
   input  logic [C_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]                  M_AXI_RRESP
);
   state_e state_q, state_d;
   logic [9:0] idx_q, idx_d;
   logic [1:0] op_q;
   logic [7:0] fill_q;
   logic [31:0] word_q, wdata, rdata;
   logic err_q, accept, start, rw, ack, resp_err, abort;
   logic [C_AXI_ADDR_WIDTH-1:0] addr;
   assign cmd_ready = state_q == S_IDLE || state_q == S_DONE;
   assign accept = cmd_valid && cmd_ready;
   assign busy = !cmd_ready;
   assign done = state_q == S_DONE;
   assign err = err_q;
`ifdef VGA_TXT_ERR_ABORT_EN
   assign abort = resp_err;
`else
   assign abort = 1'b0;
`endif
   assign start = state_q == S_RD_REQ || state_q == S_WR_REQ;
   assign rw = state_q == S_WR_REQ;
   assign addr = C_AXI_ADDR_WIDTH'({(state_q == S_RD_REQ ? idx_q + ROW_WORDS : idx_q), 2'b00});
   // the bottom row of a scroll and every CLEAR word come from the latched fill byte
   assign wdata = (op_q == OP_CLEAR || idx_q > SCROLL_SRC_LAST) ? {4{fill_q}} : word_q;
   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      if (cmd_ready) begin
         state_d = S_IDLE;
         if (cmd_valid) begin
            idx_d = '0;
            state_d = cmd_op == OP_CLEAR ? S_WR_REQ : cmd_op == OP_SCROLL_UP ? S_RD_REQ : S_DONE;
         end
      end else if (state_q == S_RD_REQ) state_d = S_RD_WAIT;
      else if (state_q == S_WR_REQ) state_d = S_WR_RESP;
      else if (ack) begin
         if (abort || (state_q == S_WR_RESP && idx_q == LAST_WORD)) state_d = S_DONE;
         else if (state_q == S_RD_WAIT) state_d = S_WR_REQ;
         else begin
            idx_d = idx_q + 10'd1;
            state_d = (op_q == OP_SCROLL_UP && idx_q < SCROLL_SRC_LAST) ? S_RD_REQ : S_WR_REQ;
         end
      end
   end
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
      if (!S_AXI_ARESETN) begin
         state_q <= S_IDLE;
         idx_q <= '0;
         op_q <= OP_CLEAR;
         fill_q <= '0;
         word_q <= '0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         if (accept) begin
            op_q <= cmd_op;
            fill_q <= cmd_fill;
         end
         if (ack && state_q == S_RD_WAIT) word_q <= rdata;
         err_q <= accept ? 1'b0 : err_q || resp_err;
      end
   axil_single_beat #(.AW(C_AXI_ADDR_WIDTH)) u_axil (
      .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .resp_err(resp_err),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_AWADDR(M_AXI_AWADDR),
      .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_BVALID(M_AXI_BVALID),
      .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_ARVALID(M_AXI_ARVALID),
      .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY), .M_AXI_RDATA(M_AXI_RDATA),
      .M_AXI_RRESP(M_AXI_RRESP)
   );
endmodule

// File: tb/tb_vga_txt_scroll_ctl.sv
// tb_vga_txt_scroll_ctl: randomized AXI4-Lite slave with a 600-word memory and a screen-level reference model.
module tb_vga_txt_scroll_ctl;
   logic clk = 1'b0, rst_n = 1'b1;
   always #5 clk = ~clk;
   logic cmd_valid = 1'b0, cmd_ready, busy, done, err;
   logic [1:0] cmd_op = 2'b00;
   logic [7:0] cmd_fill = 8'h00;
   logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [11:0] awaddr, araddr;
   logic [2:0] awprot, arprot;
   logic [31:0] wdata, rdata;
   logic [3:0] wstrb;
   logic [1:0] bresp, rresp;
   int compared = 0, mismatched = 0;

   vga_txt_scroll_ctl dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_fill(cmd_fill), .busy(busy), .done(done), .err(err),
      .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
      .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
      .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp),
      .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp)
   );

   logic [31:0] mem [600];
   logic [31:0] old_mem [600];
   logic [31:0] exp_mem [600];
   logic [11:0] wr_log [2048];
   int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, done_cnt = 0, proto_err = 0;
   int aw_dly = 0, w_dly = 0;
   bit rnd = 0, do_init = 0, init_seq = 0;
   logic [11:0] err_addr = 12'hFFF;
   int aw_wt, w_wt, ar_wt, aw_lim, w_lim, ar_lim;
   logic aw_got, w_got, ar_got, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
   logic [11:0] aw_a, ar_a, p_awa, p_ara;
   logic [31:0] w_d, p_wd;

   assign awready = awvalid && !aw_got && aw_wt >= aw_lim;
   assign wready = wvalid && !w_got && w_wt >= w_lim;
   assign arready = arvalid && !ar_got && !rvalid && ar_wt >= ar_lim;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_got <= 0; w_got <= 0; ar_got <= 0; bvalid <= 0; rvalid <= 0;
         aw_wt <= 0; w_wt <= 0; ar_wt <= 0; aw_lim <= aw_dly; w_lim <= w_dly; ar_lim <= 0;
         p_awv <= 0; p_wv <= 0; p_arv <= 0; p_awr <= 0; p_wr <= 0; p_arr <= 0;
      end else begin
         p_awv <= awvalid; p_awr <= awready; p_awa <= awaddr;
         p_wv <= wvalid; p_wr <= wready; p_wd <= wdata;
         p_arv <= arvalid; p_arr <= arready; p_ara <= araddr;
         if ((p_awv && !p_awr && (!awvalid || awaddr !== p_awa)) || (p_wv && !p_wr && (!wvalid || wdata !== p_wd)) ||
             (p_arv && !p_arr && (!arvalid || araddr !== p_ara)) || (awvalid && (awaddr >= 12'd2400 || awprot !== 3'b000)) ||
             (arvalid && (araddr >= 12'd2400 || arprot !== 3'b000)) || (wvalid && wstrb !== 4'hF))
            proto_err <= proto_err + 1;
         if (awvalid && awready) begin
            aw_got <= 1; aw_a <= awaddr; wr_log[aw_hs % 2048] <= awaddr; aw_hs <= aw_hs + 1; aw_wt <= 0;
            aw_lim <= rnd ? int'($urandom_range(0, 3)) : aw_dly;
         end else if (awvalid) aw_wt <= aw_wt + 1;
         if (wvalid && wready) begin
            w_got <= 1; w_d <= wdata; w_hs <= w_hs + 1; w_wt <= 0;
            w_lim <= rnd ? int'($urandom_range(0, 3)) : w_dly;
         end else if (wvalid) w_wt <= w_wt + 1;
         if (aw_got && w_got && !bvalid) begin
            bvalid <= 1; bresp <= aw_a == err_addr ? 2'b10 : 2'b00;
            if (aw_a < 12'd2400) mem[aw_a[11:2]] <= w_d;
            aw_got <= 0; w_got <= 0;
         end
         if (bvalid && bready) begin bvalid <= 0; b_hs <= b_hs + 1; end
         if (arvalid && arready) begin
            ar_got <= 1; ar_a <= araddr; ar_hs <= ar_hs + 1; ar_wt <= 0;
            ar_lim <= rnd ? int'($urandom_range(0, 3)) : 0;
         end else if (arvalid) ar_wt <= ar_wt + 1;
         if (ar_got && !rvalid) begin
            rvalid <= 1; rresp <= 2'b00; ar_got <= 0;
            rdata <= ar_a < 12'd2400 ? mem[ar_a[11:2]] : 32'hDEAD_BEEF;
         end
         if (rvalid && rready) begin rvalid <= 0; r_hs <= r_hs + 1; end
         if (do_init) for (int k = 0; k < 600; k++) mem[k] <= init_seq ? 32'(k) : $urandom;
      end
   end

   always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

   // screen-level rule: scroll moves every word up one row, vacated/cleared words take the fill pattern
   function automatic void build_exp(input logic [1:0] op, input logic [7:0] fill);
      for (int k = 0; k < 600; k++) exp_mem[k] = (op == 2'b01 && k < 580) ? old_mem[k + 20] : {4{fill}};
   endfunction

   function automatic int mem_diffs();
      int n = 0;
      for (int k = 0; k < 600; k++) if (mem[k] !== exp_mem[k]) n++;
      return n;
   endfunction

   task automatic init_mem(input bit seq);
      @(negedge clk); init_seq = seq; do_init = 1;
      @(negedge clk); do_init = 0;
      for (int k = 0; k < 600; k++) old_mem[k] = mem[k];
   endtask

   task automatic issue(input logic [1:0] op, input logic [7:0] fill);
      @(negedge clk);
      compared++;
      if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL issue_ready: cmd_ready=%b want 1", cmd_ready); end
      cmd_valid = 1; cmd_op = op; cmd_fill = fill;
      @(negedge clk);
      cmd_valid = 0;
   endtask

   task automatic wait_done(input string name, input int max);
      int n = 0;
      while (done !== 1'b1 && n < max) begin @(negedge clk); n++; end
      compared++;
      if (done !== 1'b1) begin mismatched++; $display("FAIL %s_done: no done after %0d cycles, want done=1", name, max); end
   endtask

   task automatic test_reset();
      #1 rst_n = 0;
      repeat (3) @(negedge clk);
      compared++;
      if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin
         mismatched++; $display("FAIL reset_valids: got %b want 00000", {awvalid, wvalid, arvalid, bready, rready});
      end
      rst_n = 1;
      @(negedge clk);
      compared++;
      if ({cmd_ready, busy, done, err} !== 4'b1000) begin
         mismatched++; $display("FAIL reset_status: ready/busy/done/err=%b want 1000", {cmd_ready, busy, done, err});
      end
      compared++;
      if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin
         mismatched++; $display("FAIL reset_idle_valids: got %b want 00000", {awvalid, wvalid, arvalid, bready, rready});
      end
   endtask

   task automatic test_clear();
      int a0, r0, d0, bad;
      rnd = 0; aw_dly = 0; w_dly = 0; err_addr = 12'hFFF;
      init_mem(0);
      a0 = aw_hs; r0 = ar_hs; d0 = done_cnt;
      issue(2'b00, 8'h20);
      wait_done("clear", 20000);
      build_exp(2'b00, 8'h20);
      compared++;
      if (b_hs - a0 != 600 || aw_hs - a0 != 600 || w_hs - a0 != 600) begin
         mismatched++; $display("FAIL clear_writes: aw=%0d w=%0d b=%0d want 600", aw_hs - a0, w_hs - a0, b_hs - a0);
      end
      compared++;
      if (ar_hs != r0) begin mismatched++; $display("FAIL clear_reads: got %0d want 0", ar_hs - r0); end
      bad = 0;
      for (int i = 0; i < 600; i++) if (wr_log[(a0 + i) % 2048] !== 12'(i * 4)) bad++;
      compared++;
      if (bad != 0) begin mismatched++; $display("FAIL clear_addr_order: %0d out-of-order addresses want 0", bad); end
      compared++;
      if (mem_diffs() != 0) begin mismatched++; $display("FAIL clear_mem: %0d wrong words want 0", mem_diffs()); end
      compared++;
      if ({cmd_ready, err} !== 2'b10) begin mismatched++; $display("FAIL clear_status: ready/err=%b want 10", {cmd_ready, err}); end
      @(negedge clk);
      compared++;
      if (done !== 1'b0 || done_cnt - d0 != 1) begin
         mismatched++; $display("FAIL clear_done_pulse: done=%b pulses=%0d want 0/1", done, done_cnt - d0);
      end
   endtask

   task automatic test_scroll(input bit random_ready, input int awd, input int wd, input bit seq, input logic [7:0] fill);
      int a0, w0, b0, r0, d0;
      rnd = random_ready; aw_dly = awd; w_dly = wd; err_addr = 12'hFFF;
      init_mem(seq);
      a0 = aw_hs; w0 = w_hs; b0 = b_hs; r0 = ar_hs; d0 = done_cnt;
      issue(2'b01, fill);
      wait_done("scroll", 40000);
      build_exp(2'b01, fill);
      compared++;
      if (aw_hs - a0 != 600 || w_hs - w0 != 600 || b_hs - b0 != 600) begin
         mismatched++; $display("FAIL scroll_writes: aw=%0d w=%0d b=%0d want 600", aw_hs - a0, w_hs - w0, b_hs - b0);
      end
      compared++;
      if (ar_hs - r0 != 580 || r_hs - r0 != 580) begin
         mismatched++; $display("FAIL scroll_reads: ar=%0d r=%0d want 580", ar_hs - r0, r_hs - r0);
      end
      compared++;
      if (mem_diffs() != 0) begin mismatched++; $display("FAIL scroll_mem: %0d wrong words want 0", mem_diffs()); end
      compared++;
      if (err !== 1'b0 || proto_err != 0) begin
         mismatched++; $display("FAIL scroll_err_proto: err=%b protocol_violations=%0d want 0/0", err, proto_err);
      end
      @(negedge clk);
      compared++;
      if (done_cnt - d0 != 1) begin mismatched++; $display("FAIL scroll_done_pulse: pulses=%0d want 1", done_cnt - d0); end
   endtask

   task automatic test_err_resp();
      int b0, nexp;
      rnd = 0; aw_dly = 0; w_dly = 0; err_addr = 12'h014;
      init_mem(0);
      b0 = b_hs;
      issue(2'b00, 8'h41);
      wait_done("err", 20000);
`ifdef VGA_TXT_ERR_ABORT_EN
      nexp = 6;
`else
      nexp = 600;
`endif
      for (int k = 0; k < 600; k++) exp_mem[k] = k < nexp ? 32'h41414141 : old_mem[k];
      compared++;
      if (err !== 1'b1) begin mismatched++; $display("FAIL err_sticky: err=%b want 1", err); end
      compared++;
      if (b_hs - b0 != nexp) begin mismatched++; $display("FAIL err_writes: got %0d want %0d", b_hs - b0, nexp); end
      compared++;
      if (mem_diffs() != 0) begin mismatched++; $display("FAIL err_mem: %0d wrong words want 0", mem_diffs()); end
      err_addr = 12'hFFF;
   endtask

   task automatic test_busy_ignore();
      int a0, d0;
      rnd = 0;
      init_mem(0);
      a0 = aw_hs; d0 = done_cnt;
      @(negedge clk); cmd_valid = 1; cmd_op = 2'b00; cmd_fill = 8'h55;
      @(negedge clk); cmd_fill = 8'h77;
      compared++;
      if ({err, busy, cmd_ready} !== 3'b010) begin
         mismatched++; $display("FAIL busy_accept: err/busy/ready=%b want 010", {err, busy, cmd_ready});
      end
      repeat (300) @(negedge clk);
      cmd_valid = 0;
      wait_done("busy", 20000);
      build_exp(2'b00, 8'h55);
      compared++;
      if (aw_hs - a0 != 600) begin mismatched++; $display("FAIL busy_writes: got %0d want 600", aw_hs - a0); end
      compared++;
      if (mem_diffs() != 0) begin mismatched++; $display("FAIL busy_mem: %0d wrong words want 0", mem_diffs()); end
      repeat (3) @(negedge clk);
      compared++;
      if (done_cnt - d0 != 1) begin mismatched++; $display("FAIL busy_done_count: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_bad_op();
      int a0, r0, d0;
      a0 = aw_hs; r0 = ar_hs; d0 = done_cnt;
      issue(2'b11, 8'h99);
      compared++;
      if ({done, busy} !== 2'b10) begin mismatched++; $display("FAIL badop_done: done/busy=%b want 10", {done, busy}); end
      @(negedge clk);
      compared++;
      if (done !== 1'b0) begin mismatched++; $display("FAIL badop_pulse: done=%b want 0", done); end
      repeat (5) @(negedge clk);
      compared++;
      if (aw_hs != a0 || ar_hs != r0 || done_cnt - d0 != 1) begin
         mismatched++; $display("FAIL badop_traffic: aw=%0d ar=%0d pulses=%0d want 0/0/1", aw_hs - a0, ar_hs - r0, done_cnt - d0);
      end
   endtask

   task automatic test_reset_mid();
      int a0, n;
      rnd = 0; aw_dly = 2; w_dly = 1;
      init_mem(1);
      issue(2'b01, 8'h00);
      repeat (60) @(negedge clk);
      n = 0;
      while (!(awvalid || arvalid) && n < 40) begin @(negedge clk); n++; end
      compared++;
      if (!(awvalid || arvalid)) begin mismatched++; $display("FAIL midrst_setup: no valid seen want a VALID high"); end
      #2 rst_n = 0;
      #1;
      compared++;
      if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin
         mismatched++; $display("FAIL midrst_valids: got %b want 00000", {awvalid, wvalid, arvalid, bready, rready});
      end
      @(negedge clk); rst_n = 1;
      @(negedge clk);
      compared++;
      if ({cmd_ready, busy, done} !== 3'b100) begin
         mismatched++; $display("FAIL midrst_idle: ready/busy/done=%b want 100", {cmd_ready, busy, done});
      end
      aw_dly = 0; w_dly = 0;
      for (int k = 0; k < 600; k++) old_mem[k] = mem[k];
      a0 = aw_hs;
      issue(2'b00, 8'h33);
      wait_done("midrst_clear", 20000);
      build_exp(2'b00, 8'h33);
      compared++;
      if (aw_hs - a0 != 600 || mem_diffs() != 0) begin
         mismatched++; $display("FAIL midrst_clear: writes=%0d bad_words=%0d want 600/0", aw_hs - a0, mem_diffs());
      end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_scroll(1, 0, 0, 1, 8'h00);
      test_scroll(0, 3, 0, 0, 8'h2E);
      test_err_resp();
      test_busy_ignore();
      test_bad_op();
      test_reset_mid();
      compared++;
      if (proto_err != 0) begin mismatched++; $display("FAIL protocol: %0d violations want 0", proto_err); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
